// File: rtl/huff_pkg.sv
// Shared types and constants for the Huffman bitstream packer.
// HUFF_BYTE_STUFF_EN (see huff_byte_stuffer) selects JPEG 0xFF stuffing.
package huff_pkg;
   typedef enum logic [1:0] {RUN, STUFF, PAD, DONE} state_t;

   localparam logic [7:0] STUFF_TRIGGER = 8'hFF;
   localparam logic [7:0] STUFF_BYTE    = 8'h00;
   localparam logic       PAD_BIT       = 1'b1;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/huff_byte_stuffer.sv
// Single-entry output byte register with JPEG 0xFF -> 0xFF,0x00 insertion.
// Stuffing only exists when HUFF_BYTE_STUFF_EN is defined; otherwise bytes pass raw.
module huff_byte_stuffer
   import huff_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_byte,
   input  logic [3:0] in_bits,
   input  logic       in_last,
   output logic       stuffing,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_byte,
   output logic [3:0] out_data_bits,
   output logic       out_last
);
   state_t st;
   logic   last_hold;
   logic   slot_free;

   assign slot_free = !out_valid || out_ready;
   assign stuffing  = (st == STUFF);
   assign in_ready  = slot_free && !stuffing;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         st            <= RUN;
         last_hold     <= 1'b0;
         out_valid     <= 1'b0;
         out_byte      <= '0;
         out_data_bits <= '0;
         out_last      <= 1'b0;
      end else if (slot_free) begin
         if (stuffing) begin
            // the inserted zero inherits the end-of-segment flag of the 0xFF
            out_valid     <= 1'b1;
            out_byte      <= STUFF_BYTE;
            out_data_bits <= 4'd0;
            out_last      <= last_hold;
            st            <= RUN;
         end else if (in_valid) begin
            out_valid     <= 1'b1;
            out_byte      <= in_byte;
            out_data_bits <= in_bits;
            last_hold     <= in_last;
`ifdef HUFF_BYTE_STUFF_EN
            if (in_byte == STUFF_TRIGGER) begin
               out_last <= 1'b0;
               st       <= STUFF;
            end else begin
               out_last <= in_last;
            end
`else
            out_last <= in_last;
`endif
         end else begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/huffman_bitstream_packer.sv
// Packs right-aligned variable-length code words MSB-first into bytes, pads with
// ones on flush. Byte stuffing is enabled by HUFF_BYTE_STUFF_EN.
module huffman_bitstream_packer
   import huff_pkg::*;
#(
   parameter int CODE_W = 32,
   parameter int LEN_W  = clog2(CODE_W + 1),
   parameter int ACC_W  = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   input  logic [LEN_W-1:0]  in_len,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_byte,
   output logic [3:0]        out_data_bits,
   output logic              out_last,
   output logic              done
);
   localparam int CNT_W = clog2(ACC_W + 1);
   localparam logic [CNT_W-1:0] C8      = CNT_W'(8);
   localparam logic [CNT_W-1:0] RDY_MAX = CNT_W'(ACC_W - CODE_W);

   state_t             state;
   logic [ACC_W-1:0]   acc, acc_next, ins;
   logic [CNT_W-1:0]   cnt, cnt_p, cnt_next, pop_bits;
   logic [CNT_W:0]     sh;
   logic [LEN_W-1:0]   len_c;
   logic [CODE_W-1:0]  code_m;
   logic               take, offer, pop, st_ready, stuffing;
   logic [7:0]         top_byte;
   logic [3:0]         offer_bits;
   logic               offer_last;

   assign in_ready = !reset && (state == RUN) && !stuffing && (cnt <= RDY_MAX);
   assign take     = in_valid && in_ready;
   assign len_c    = (in_len > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : in_len;
   assign code_m   = in_code & ~({CODE_W{1'b1}} << len_c);

   // a partial byte is only offered while flushing, topped up with pad bits
   assign offer      = (cnt >= C8) || ((state == PAD) && (cnt != '0));
   assign top_byte   = acc[ACC_W-1 -: 8] | ((cnt < C8) ? ({8{PAD_BIT}} >> cnt) : 8'h00);
   assign offer_bits = (cnt >= C8) ? 4'd8 : cnt[3:0];
   assign offer_last = (state == PAD) && (cnt <= C8);
   assign pop        = offer && st_ready;
   assign pop_bits   = pop ? ((cnt >= C8) ? C8 : cnt) : '0;

   // new code lands right after the bits that survive this cycle's pop
   assign cnt_p    = cnt - pop_bits;
   assign cnt_next = cnt_p + (take ? CNT_W'(len_c) : '0);
   assign sh       = (CNT_W+1)'(ACC_W) - {1'b0, cnt_p} - (CNT_W+1)'(len_c);
   assign ins      = {{(ACC_W-CODE_W){1'b0}}, code_m} << sh;
   assign acc_next = (acc << pop_bits) | (take ? ins : '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc   <= '0;
         cnt   <= '0;
         state <= RUN;
         done  <= 1'b0;
      end else begin
         acc  <= acc_next;
         cnt  <= cnt_next;
         done <= 1'b0;
         case (state)
            RUN: if (take && in_last) begin
               if (cnt_next == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state <= PAD;
               end
            end
            PAD: if (out_valid && out_ready && out_last) begin
               state <= DONE;
               done  <= 1'b1;
            end
            default: state <= RUN;
         endcase
      end
   end

   huff_byte_stuffer u_stuffer (
      .clock         (clock),
      .reset         (reset),
      .in_valid      (offer),
      .in_ready      (st_ready),
      .in_byte       (top_byte),
      .in_bits       (offer_bits),
      .in_last       (offer_last),
      .stuffing      (stuffing),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_byte      (out_byte),
      .out_data_bits (out_data_bits),
      .out_last      (out_last)
   );
endmodule

// File: tb/tb_huffman_bitstream_packer.sv
// Bench for huffman_bitstream_packer: bit-queue reference model plus a byte monitor.
// Follows HUFF_BYTE_STUFF_EN the same way the design does.
module tb_huffman_bitstream_packer;
   localparam int CODE_W = 32;
   localparam int LEN_W  = 6;
   localparam int ACC_W  = 64;
`ifdef HUFF_BYTE_STUFF_EN
   localparam bit STUFF_EN = 1'b1;
`else
   localparam bit STUFF_EN = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [CODE_W-1:0] in_code = '0;
   logic [LEN_W-1:0]  in_len = '0;
   logic              in_last = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [7:0]        out_byte;
   logic [3:0]        out_data_bits;
   logic              out_last;
   logic              done;

   always #5 clock = ~clock;

   huffman_bitstream_packer #(.CODE_W(CODE_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_code(in_code), .in_len(in_len), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_byte(out_byte), .out_data_bits(out_data_bits),
      .out_last(out_last), .done(done)
   );

   typedef struct packed {logic [7:0] b; logic [3:0] bits; logic last;} ob_t;

   ob_t exp_q[$];
   bit  seg_bits[$];
   int  checks = 0, passed = 0;
   int  cyc = 0, n_acc = 0, done_cnt = 0, done_cyc = -10, last_acc_cyc = -20, ir_low = 0;
   int  rmode = 0;
   bit  hold_v = 0, done_prev = 0;
   ob_t held, mon_e;

   // reference: segment as a bit queue, cut into bytes, pad with ones, stuff 0xFF
   function automatic void emit(bit is_last);
      logic [7:0] b;
      int k;
      b = 8'hFF;
      k = 0;
      for (int i = 7; i >= 0 && seg_bits.size() > 0; i--) begin
         b[i] = seg_bits.pop_front();
         k++;
      end
      if (STUFF_EN && b == 8'hFF) begin
         exp_q.push_back('{b, 4'(k), 1'b0});
         exp_q.push_back('{8'h00, 4'd0, is_last});
      end else begin
         exp_q.push_back('{b, 4'(k), is_last});
      end
   endfunction

   function automatic void model_push(logic [31:0] c, int l, bit last);
      int n;
      n = (l > CODE_W) ? CODE_W : l;
      for (int i = n - 1; i >= 0; i--) seg_bits.push_back(c[i]);
      if (last) while (seg_bits.size() > 0) emit(seg_bits.size() <= 8);
      else      while (seg_bits.size() >= 8) emit(1'b0);
   endfunction

   // out_ready pattern changes just after the active edge
   initial forever begin
      @(posedge clock);
      #1;
      case (rmode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         2:       out_ready = ($urandom_range(0, 3) != 0);
         default: out_ready = 1'b0;
      endcase
   end

   always @(negedge clock) begin
      cyc++;
      if (reset) begin
         hold_v    = 0;
         done_prev = 0;
      end else begin
         if (hold_v) begin
            checks++;
            if (!out_valid || {out_byte, out_data_bits, out_last} !== held)
               $display("FAIL stall_stable got v=%b %h/%0d/%b want %h/%0d/%b", out_valid,
                        out_byte, out_data_bits, out_last, held.b, held.bits, held.last);
            else passed++;
         end
         if (out_valid && out_ready) begin
            n_acc++;
            checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_byte got %h/%0d/%b want none", out_byte, out_data_bits, out_last);
            end else begin
               mon_e = exp_q.pop_front();
               if ({out_byte, out_data_bits, out_last} !== mon_e)
                  $display("FAIL byte got %h/%0d/%b want %h/%0d/%b", out_byte, out_data_bits,
                           out_last, mon_e.b, mon_e.bits, mon_e.last);
               else passed++;
            end
            if (out_last) last_acc_cyc = cyc;
         end
         hold_v = out_valid && !out_ready;
         held   = '{out_byte, out_data_bits, out_last};
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            checks++;
            if (done_prev) $display("FAIL done_width got 2+ cycles want 1");
            else passed++;
         end
         done_prev = done;
      end
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic send(input logic [31:0] c, input int l, input bit last);
      int t;
      t = 0;
      in_code  = c;
      in_len   = LEN_W'(l);
      in_last  = last;
      in_valid = 1'b1;
      while (!in_ready && t < 2000) begin
         tick();
         t++;
         ir_low++;
      end
      if (t >= 2000) begin
         checks++;
         $display("FAIL send_timeout got in_ready=0 want 1");
      end else begin
         model_push(c, l, last);
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int t;
      t = 0;
      while (done_cnt == d0 && t < 3000) begin
         tick();
         t++;
      end
      repeat (2) tick();
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      repeat (3) tick();
      checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else passed++;
      checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else passed++;
      checks++; if (out_byte !== 8'h00) $display("FAIL rst_out_byte got %h want 00", out_byte); else passed++;
      checks++; if (out_data_bits !== 4'd0) $display("FAIL rst_bits got %0d want 0", out_data_bits); else passed++;
      checks++; if ({out_last, done} !== 2'b00) $display("FAIL rst_last_done got %b want 00", {out_last, done}); else passed++;
      reset = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", in_ready); else passed++;
   endtask

   task automatic test_basic();
      int d0, a0;
      d0 = done_cnt; a0 = n_acc; rmode = 0;
      send(32'h0, 2, 1'b0);
      send(32'hA, 4, 1'b1);
      wait_done(d0);
      checks++; if (done_cnt != d0 + 1) $display("FAIL basic_done got %0d want 1", done_cnt - d0); else passed++;
      checks++; if (n_acc - a0 != 1) $display("FAIL basic_nbytes got %0d want 1", n_acc - a0); else passed++;
      checks++; if (done_cyc != last_acc_cyc + 1) $display("FAIL basic_done_lat got %0d want 1", done_cyc - last_acc_cyc); else passed++;
      checks++; if (exp_q.size() != 0) $display("FAIL basic_left got %0d want 0", exp_q.size()); else passed++;
   endtask

   task automatic test_stuff();
      int d0, a0;
      d0 = done_cnt; a0 = n_acc; rmode = 0;
      send(32'hFF, 8, 1'b0);
      send(32'h1, 1, 1'b1);
      wait_done(d0);
      checks++; if (n_acc - a0 != (STUFF_EN ? 4 : 2)) $display("FAIL stuff_nbytes got %0d want %0d", n_acc - a0, STUFF_EN ? 4 : 2); else passed++;
      checks++; if (done_cnt != d0 + 1) $display("FAIL stuff_done got %0d want 1", done_cnt - d0); else passed++;
   endtask

   task automatic test_back_to_back();
      int d0, a0, r0;
      d0 = done_cnt; a0 = n_acc; r0 = ir_low; rmode = 1;
      for (int k = 0; k < 12; k++) send(32'hABCDE, 20, k == 11);
      wait_done(d0);
      checks++; if (n_acc - a0 != 30) $display("FAIL b2b_nbytes got %0d want 30", n_acc - a0); else passed++;
      checks++; if (ir_low == r0) $display("FAIL b2b_backpressure got no in_ready drop want drop"); else passed++;
      checks++; if (exp_q.size() != 0) $display("FAIL b2b_left got %0d want 0", exp_q.size()); else passed++;
   endtask

   task automatic test_len_edge();
      int d0, a0;
      d0 = done_cnt; a0 = n_acc; rmode = 0;
      send(32'hFFFFFFFF, 3, 1'b0);
      send(32'hFFFFFFFF, 0, 1'b0);
      send(32'h0, 5, 1'b1);
      wait_done(d0);
      checks++; if (n_acc - a0 != 1) $display("FAIL len_nbytes got %0d want 1", n_acc - a0); else passed++;
      checks++; if (done_cnt != d0 + 1) $display("FAIL len_done got %0d want 1", done_cnt - d0); else passed++;
   endtask

   task automatic test_empty_flush();
      int d0, a0;
      d0 = done_cnt; a0 = n_acc; rmode = 0;
      send(32'h1234, 0, 1'b1);
      checks++; if (done !== 1'b1) $display("FAIL empty_done got %b want 1", done); else passed++;
      checks++; if (in_ready !== 1'b0) $display("FAIL empty_ready0 got %b want 0", in_ready); else passed++;
      tick();
      checks++; if ({in_ready, done} !== 2'b10) $display("FAIL empty_ready1 got %b want 10", {in_ready, done}); else passed++;
      repeat (3) tick();
      checks++; if (n_acc != a0 || done_cnt != d0 + 1) $display("FAIL empty_quiet got %0d bytes %0d done want 0/1", n_acc - a0, done_cnt - d0); else passed++;
   endtask

   task automatic test_reset_mid();
      int d0, a0, t;
      d0 = done_cnt; a0 = n_acc; rmode = 3; t = 0;
      repeat (2) tick();
      send(32'h5, 3, 1'b1);
      while (!out_valid && t < 20) begin tick(); t++; end
      checks++; if ({out_valid, out_byte, out_last} !== {1'b1, 8'hBF, 1'b1}) $display("FAIL mid_pending got %b/%h/%b want 1/bf/1", out_valid, out_byte, out_last); else passed++;
      reset = 1'b1;
      #1;
      checks++; if ({out_valid, out_last, done, in_ready} !== 4'b0000) $display("FAIL mid_reset got %b want 0000", {out_valid, out_last, done, in_ready}); else passed++;
      exp_q.delete();
      seg_bits.delete();
      repeat (2) tick();
      reset = 1'b0;
      rmode = 0;
      repeat (5) tick();
      checks++; if (done_cnt != d0 || n_acc != a0 || out_valid !== 1'b0) $display("FAIL mid_quiet got done=%0d bytes=%0d v=%b want 0/0/0", done_cnt - d0, n_acc - a0, out_valid); else passed++;
      test_basic();
   endtask

   task automatic test_random();
      int d0, nc, l;
      logic [31:0] c;
      rmode = 2;
      for (int s = 0; s < 4; s++) begin
         d0 = done_cnt;
         nc = $urandom_range(3, 14);
         for (int k = 0; k < nc; k++) begin
            c = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom();
            l = (k == nc - 1) ? $urandom_range(1, 32) : $urandom_range(0, 40);
            send(c, l, k == nc - 1);
         end
         wait_done(d0);
         checks++; if (done_cnt != d0 + 1) $display("FAIL rand_done seg %0d got %0d want 1", s, done_cnt - d0); else passed++;
         checks++; if (exp_q.size() != 0) $display("FAIL rand_left seg %0d got %0d want 0", s, exp_q.size()); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stuff();
      test_back_to_back();
      test_len_edge();
      test_empty_flush();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/huffman_bitstream_packer.md
Name: huffman_bitstream_packer

Overview:
Parametrised successor to the fixed-width Huffman encoder output stage. Takes a stream of variable-length Huffman/amplitude code words (right-aligned value plus bit length) from the DC/AC encoders and packs them MSB-first into a JPEG entropy-coded byte stream. Applies 0xFF→0xFF,0x00 byte stuffing and 1-bit padding at block/scan end. Uses valid/ready on both sides so it sits between the encoders and the JPEG output FIFO.

Parameters:
CODE_W, 32, max bits per input code word (DC = 24, AC = 32)
LEN_W, $clog2(CODE_W+1), width of in_len
ACC_W, 64, bit accumulator width; must be ≥ CODE_W+8

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  code word valid
in_ready  out  1  packer can accept a code word
in_code  in  CODE_W  code bits, right-aligned; bits at and above in_len are ignored
in_len  in  LEN_W  number of valid bits, 0..CODE_W
in_last  in  1  flush (pad to byte) after this code word
out_valid  out  1  out_byte valid
out_ready  in  1  downstream accepts byte
out_byte  out  8  stream byte
out_data_bits  out  4  real (unpadded) bits in out_byte, 1..8; 0 on stuffed 0x00
out_last  out  1  final byte of flushed segment
done  out  1  one-cycle pulse: flush complete

Behaviour:
- Reset: acc=0, cnt=0, state=RUN. All outputs 0 except in_ready, which is 0 during reset and 1 on the first cycle after release.
- Input handshake: transfer when in_valid&in_ready.
  - in_ready = (state==RUN) & (cnt ≤ ACC_W−CODE_W). No combinational path from in_* to in_ready.
  - in_len > CODE_W is clamped to CODE_W.
  - in_len = 0 is legal; it adds no bits.
- Accumulator: left-aligned, MSB-first.
  - Append places the masked code immediately after the current cnt bits.
  - Same-cycle pop of the top byte and append are both legal: cnt_next = cnt + len − 8·pop.
- Output register: a single-entry byte register.
  - Loaded when empty, or when its byte is being accepted (out_valid&out_ready), and cnt ≥ 8.
  - out_valid rises the cycle after the append edge that makes cnt ≥ 8.
  - Sustains 1 byte/cycle when out_ready stays high.
  - out_byte, out_data_bits and out_last hold stable while out_valid&!out_ready.
- States:
  - RUN: normal packing.
  - STUFF: entered when a 0xFF byte is loaded. The next load is forced to 0x00 (data_bits 0), then return to RUN or PAD. No accumulator pop occurs in STUFF.
  - PAD: entered after accepting in_last. in_ready=0. Drain full bytes. If 0 < cnt < 8, load (acc_top | ones) as a padded byte with out_data_bits = cnt. Stuffing applies to a padded 0xFF. The final emitted byte (the stuffed 0x00 if present) carries out_last.
  - DONE: entered after the out_last byte is accepted. Pulse done for 1 cycle, then go to RUN.
    - If cnt = 0 and no byte is pending at in_last, do not emit out_last; pulse done on the next cycle.
- Flush while the output is stalled: PAD waits; no bits are lost.
- Reset mid-operation: all partial bits and the pending byte are discarded; no out_last or done is produced.

Optional Feature:
HUFF_BYTE_STUFF_EN.
- Defined: 0xFF stuffing as above (JPEG-compliant ECS).
- Undefined: the STUFF state is removed, no 0x00 bytes are inserted, and 0xFF passes through unchanged (raw debug stream). All other behaviour is identical.

Decomposition:
- Package huff_pkg:
  - state enum {RUN, STUFF, PAD, DONE}
  - constants STUFF_TRIGGER=8'hFF, STUFF_BYTE=8'h00, PAD_BIT=1'b1
  - clog2 helper for LEN_W
- Sub-module huff_byte_stuffer: output register plus STUFF logic, valid/ready in and out, macro-controlled.
- Accumulator and PAD control remain in the top level.

Test Plan:
1. Codes {00,len2},{1010,len4,last}, out_ready=1 → one byte 0x2B, data_bits 6, out_last=1, done pulses 1 cycle after.
2. Codes {0xFF,len8},{1,len1,last} → bytes 0xFF, 0x00(data_bits 0), 0xFF(data_bits 1), 0x00 with out_last; without macro → 0xFF, 0xFF(last).
3. 12 codes {0xABCDE,len20} back-to-back, out_ready toggling 1-0 → 30 bytes, exact repeating pattern AB CD EA BC DE…, out_byte stable during stalls, in_ready drops when cnt > 32.
4. in_code=0xFFFFFFFF with in_len=3, then in_len=0, then {0,len5,last} → byte 0xE0, data_bits 8; the len-0 word is accepted with no effect.
5. in_last on {x,len0} with cnt=0 → no output byte, done pulses next cycle, in_ready returns 1 the cycle after.
6. Assert reset while in PAD with out_valid=1, out_ready=0 → out_valid=0 immediately, no out_last/done, and the next stream starts clean.
